score_display_scan: RTL and testbench

Parametrised multiplexed seven-segment score display for the Pong top level. Takes two binary player scores, converts each to BCD with a serial double-dabble engine, and time-multiplexes the digits onto a shared active-low cathode bus with active-low one-hot anodes. Supersedes the fixed two-nibble display: configurable digit count, score width, refresh rate, leading-zero blanking, saturation, and optional win blinking.

---
 rtl/score_display_scan.sv | 266 ++++++++++++++++++++++++++
 tb/tb_score_display_scan.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/score_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : score_display_scan
// Purpose  : Two-player score display for the Pong top level. Each binary
//            score is converted to BCD by a serial double-dabble engine, then
//            the digits are time-multiplexed onto an active-low cathode bus
//            with active-low one-hot anodes. Supports leading-zero blanking
//            and saturation to all 9s.
// Options  : SEG_BLINK_EN - when defined, a player at or above WIN_SCORE
//            blinks with a half-period of BLINK_FRAMES scan frames.
// Revision : 1.0 - initial release
// ============================================================================
module score_display_scan #(
    parameter int NUM_DIGITS       = 8,
    parameter int DIGITS_PER_SCORE = 2,
    parameter int SCORE_W          = 7,
    parameter int REFRESH_DIV      = 100000,
    parameter int WIN_SCORE        = 11,
    parameter int BLINK_FRAMES     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    rightPlayerScore,
    input  logic [SCORE_W-1:0]    leftPlayerScore,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            cathode
);

    localparam int DPS       = DIGITS_PER_SCORE;
    localparam int DISP_W    = 4 * DPS;
    localparam int BCD_W     = 4 * (DPS + 1);   // one spare nibble flags overflow
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W     = $clog2(REFRESH_DIV);
    localparam int CNT_W     = (SCORE_W > 1) ? $clog2(SCORE_W + 1) : 1;
    localparam int SAT_LIMIT = 10 ** DPS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Elaboration-time parameter sanity checks.
    if (DPS < 1 || DPS > 4 || 2 * DPS > NUM_DIGITS) begin : g_bad_dps
        $error("score_display_scan: DIGITS_PER_SCORE out of range");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("score_display_scan: REFRESH_DIV must be at least 2");
    end
    if (BLINK_FRAMES < 1 || WIN_SCORE < 0) begin : g_bad_blink
        $error("score_display_scan: invalid blink parameters");
    end

    // Add-3 correction on every nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int n = 0; n < DPS + 1; n++) begin
            if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Bit d set when digit d (d > 0) is zero and everything above it is zero.
    function automatic logic [DPS-1:0] lz_mask(input logic [DISP_W-1:0] v);
        logic [DPS-1:0] m;
        logic           z;
        m = '0;
        z = 1'b1;
        for (int d = DPS - 1; d >= 1; d--) begin
            z    = z & (v[4*d +: 4] == 4'd0);
            m[d] = z;
        end
        return m;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic [SCORE_W-1:0]    r_snap_q, r_snap_d, l_snap_q, l_snap_d;
    logic [SCORE_W-1:0]    r_bin_q, r_bin_d, l_bin_q, l_bin_d;
    logic [BCD_W-1:0]      r_bcd_q, r_bcd_d, l_bcd_q, l_bcd_d;
    logic [DISP_W-1:0]     r_disp_q, r_disp_d, l_disp_q, l_disp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;
    logic [BCD_W-1:0]      r_adj, l_adj;
    logic                  r_sat, l_sat, presc_wrap;
    logic                  hide_r, hide_l;
    logic [DPS-1:0]        r_lz, l_lz;

    assign r_adj = dabble_adj(r_bcd_q);
    assign l_adj = dabble_adj(l_bcd_q);
    assign r_sat = (r_bcd_q[BCD_W-1 -: 4] != 4'd0) || (32'(r_snap_q) >= 32'(SAT_LIMIT));
    assign l_sat = (l_bcd_q[BCD_W-1 -: 4] != 4'd0) || (32'(l_snap_q) >= 32'(SAT_LIMIT));

    // Conversion FSM: snapshot, SCORE_W double-dabble steps, publish.
    always_comb begin
        state_d  = state_q;
        r_snap_d = r_snap_q;
        l_snap_d = l_snap_q;
        r_bin_d  = r_bin_q;
        l_bin_d  = l_bin_q;
        r_bcd_d  = r_bcd_q;
        l_bcd_d  = l_bcd_q;
        r_disp_d = r_disp_q;
        l_disp_d = l_disp_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rightPlayerScore != r_snap_q || leftPlayerScore != l_snap_q)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                r_snap_d = rightPlayerScore;
                l_snap_d = leftPlayerScore;
                r_bin_d  = rightPlayerScore;
                l_bin_d  = leftPlayerScore;
                r_bcd_d  = '0;
                l_bcd_d  = '0;
                cnt_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                r_bcd_d = {r_adj[BCD_W-2:0], r_bin_q[SCORE_W-1]};
                l_bcd_d = {l_adj[BCD_W-2:0], l_bin_q[SCORE_W-1]};
                r_bin_d = r_bin_q << 1;
                l_bin_d = l_bin_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                r_disp_d = r_sat ? {DPS{4'h9}} : r_bcd_q[DISP_W-1:0];
                l_disp_d = l_sat ? {DPS{4'h9}} : l_bcd_q[DISP_W-1:0];
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prescaler and digit index for the scan.
    always_comb begin
        presc_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (presc_wrap)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

`ifdef SEG_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic             frame_end;

    assign frame_end = presc_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign hide_r    = (32'(r_snap_q) >= 32'(WIN_SCORE)) && !blink_on_q;
    assign hide_l    = (32'(l_snap_q) >= 32'(WIN_SCORE)) && !blink_on_q;

    // Toggle blink phase every BLINK_FRAMES completed frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_end) begin
            if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    assign hide_r = 1'b0;
    assign hide_l = 1'b0;
`endif

    assign r_lz = lz_mask(r_disp_q);
    assign l_lz = lz_mask(l_disp_q);

    // Select the nibble for the current index and encode the next pin values.
    always_comb begin
        logic [3:0] nib;
        logic       blank;
        nib   = 4'hF;
        blank = 1'b1;
        for (int d = 0; d < DPS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                nib   = r_disp_q[4*d +: 4];
                blank = r_lz[d] | hide_r;
            end
            if (idx_q == IDX_W'(NUM_DIGITS - DPS + d)) begin
                nib   = l_disp_q[4*d +: 4];
                blank = l_lz[d] | hide_l;
            end
        end
        anode_d   = ~(NUM_DIGITS'(1) << idx_q);
        cathode_d = blank ? 8'hFF : seg7(nib);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            r_snap_q  <= '0;
            l_snap_q  <= '0;
            r_bin_q   <= '0;
            l_bin_q   <= '0;
            r_bcd_q   <= '0;
            l_bcd_q   <= '0;
            r_disp_q  <= '0;
            l_disp_q  <= '0;
            cnt_q     <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            r_snap_q  <= r_snap_d;
            l_snap_q  <= l_snap_d;
            r_bin_q   <= r_bin_d;
            l_bin_q   <= l_bin_d;
            r_bcd_q   <= r_bcd_d;
            l_bcd_q   <= l_bcd_d;
            r_disp_q  <= r_disp_d;
            l_disp_q  <= l_disp_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display_scan
// Purpose  : Self-checking bench for score_display_scan with REFRESH_DIV=4:
//            reset, scan order, conversion latency, a table of score pairs
//            with expected per-digit cathodes, and optional blinking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_display_scan;

    logic       clk;
    logic       reset;
    logic [6:0] r_score;
    logic [6:0] l_score;
    logic [7:0] anode;
    logic [7:0] cathode;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [6:0]  r;
        logic [6:0]  l;
        logic [63:0] exp;   // {digit7, ..., digit0}
    } vec_t;

    vec_t vecs[7];

    score_display_scan #(
        .NUM_DIGITS      (8),
        .DIGITS_PER_SCORE(2),
        .SCORE_W         (7),
        .REFRESH_DIV     (4),
        .WIN_SCORE       (11),
        .BLINK_FRAMES    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rightPlayerScore(r_score),
        .leftPlayerScore (l_score),
        .anode           (anode),
        .cathode         (cathode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    // Two scan frames; keep the last cathode seen for each lit digit.
    task automatic capture(output logic [63:0] got, output int bad_onehot);
        logic [7:0] sel;
        got        = '0;
        bad_onehot = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if ($countones(~anode) > 1) bad_onehot++;
            for (int d = 0; d < 8; d++) begin
                sel = ~(8'h01 << d);
                if (anode == sel) got[d*8 +: 8] = cathode;
            end
        end
    endtask

    initial begin
        logic [63:0] got;
        logic [7:0]  e;
        int          bad;

        vecs[0] = '{7'd7,   7'd12,  64'hF9A4FFFFFFFFFFF8};
        vecs[1] = '{7'd105, 7'd0,   64'hFFC0FFFFFFFF9090};
        vecs[2] = '{7'd0,   7'd0,   64'hFFC0FFFFFFFFFFC0};
        vecs[3] = '{7'd99,  7'd10,  64'hF9C0FFFFFFFF9090};
        vecs[4] = '{7'd100, 7'd127, 64'h9090FFFFFFFF9090};
        vecs[5] = '{7'd48,  7'd5,   64'hFF92FFFFFFFF9980};
        vecs[6] = '{7'd63,  7'd86,  64'h8082FFFFFFFF82B0};

        clk     = 1'b0;
        reset   = 1'b1;
        r_score = 7'd0;
        l_score = 7'd0;

        // Reset held for three cycles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_anode", 32'(anode), 32'hFF);
            chk("reset_cathode", 32'(cathode), 32'hFF);
        end
        reset = 1'b0;

        // j counts edges after release; scan order plus a change during SHIFT.
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j <= 40) begin
                e = ~(8'h01 << (((j - 1) / 4) % 8));
                chk($sformatf("scan_order_j%0d", j), 32'(anode), 32'(e));
            end
            if (j == 1)  chk("first_cathode", 32'(cathode), 32'hC0);
            if (j == 19) r_score = 7'd3;
            if (j == 22) r_score = 7'd5;
            if (j == 34) chk("shift_first_value_3", 32'(cathode), 32'hB0);
            if (j == 66) begin
                chk("shift_second_anode", 32'(anode), 32'hFE);
                chk("shift_second_value_5", 32'(cathode), 32'h92);
            end
        end

        // Table of score pairs with hand-derived digit patterns.
        for (int i = 0; i < 7; i++) begin
            r_score = vecs[i].r;
            l_score = vecs[i].l;
            repeat (30) @(negedge clk);
            capture(got, bad);
            chk($sformatf("vec%0d_onehot", i), 32'(bad), 32'd0);
            for (int d = 0; d < 8; d++)
                chk($sformatf("vec%0d_dig%0d", i, d), 32'(got[d*8 +: 8]),
                    32'(vecs[i].exp[d*8 +: 8]));
        end

`ifdef SEG_BLINK_EN
        begin
            int on_cnt, off_cnt, r_bad;
            on_cnt  = 0;
            off_cnt = 0;
            r_bad   = 0;
            r_score = 7'd7;
            l_score = 7'd11;
            repeat (30) @(negedge clk);
            for (int c = 0; c < 512; c++) begin
                @(negedge clk);
                if (anode == 8'h7F && cathode == 8'hF9) on_cnt++;
                if (anode == 8'h7F && cathode == 8'hFF) off_cnt++;
                if (anode == 8'hFE && cathode != 8'hF8) r_bad++;
            end
            chk("blink_on_seen", 32'(on_cnt > 0), 32'd1);
            chk("blink_off_seen", 32'(off_cnt > 0), 32'd1);
            chk("blink_right_steady", 32'(r_bad), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
